sobel_rgb_stream: RTL and testbench



---
 rtl/sobel_rgb_stream_pkg.sv | 37 +++
 rtl/sobel_rgb_stream_line_buf.sv | 38 +++
 rtl/sobel_rgb_stream.sv | 184 ++++++++++++++++++
 tb/tb_sobel_rgb_stream.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_rgb_stream_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sobel_pkg : FSM encodings and arithmetic constants for the Sobel
//             RGB edge stream.                              rev 1.0
// ------------------------------------------------------------------
package sobel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   localparam logic [7:0] GRAY_COEF_R = 8'd77;
   localparam logic [7:0] GRAY_COEF_G = 8'd150;
   localparam logic [7:0] GRAY_COEF_B = 8'd29;
   localparam int         MAG_MAX     = 255;
   localparam int         LAT_OFS     = 4;

   // Coefficients sum to 256, so the 16-bit sum never overflows.
   function automatic logic [7:0] rgb2gray(input logic [23:0] rgb);
      logic [15:0] acc;
      acc = 16'(GRAY_COEF_R) * 16'(rgb[23:16])
          + 16'(GRAY_COEF_G) * 16'(rgb[15:8])
          + 16'(GRAY_COEF_B) * 16'(rgb[7:0]);
      return acc[15:8];
   endfunction

   function automatic logic [9:0] wsum(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [7:0] c);
      return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_rgb_stream_line_buf.sv
`default_nettype none
// ------------------------------------------------------------------
// line_buf : WIDTH x 8 circular buffer; dout is the sample written
//            WIDTH writes ago (same column, previous line). rev 1.0
// ------------------------------------------------------------------
module line_buf #(
   parameter int WIDTH = 128
) (
   input  logic       clk,
   input  logic       xrst,
   input  logic       we_i,
   input  logic [7:0] din_i,
   output logic [7:0] dout_o
);

   localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [7:0]    mem_q [WIDTH];
   logic [AW-1:0] ptr_q;

   assign dout_o = mem_q[ptr_q];

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         ptr_q <= '0;
      end else if (we_i) begin
         ptr_q <= (ptr_q == AW'(WIDTH - 1)) ? '0 : ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[ptr_q] <= din_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sobel_rgb_stream.sv
`default_nettype none
// ------------------------------------------------------------------
// sobel_rgb_stream : RGB frame in, 3x3 Sobel magnitude frame out as
//                    replicated {mag,mag,mag}.              rev 1.0
// ------------------------------------------------------------------
module sobel_rgb_stream
   import sobel_pkg::*;
#(
   parameter int WIDTH  = 128,
   parameter int HEIGHT = 128
) (
   input  logic        clk,
   input  logic        xrst,
   input  logic [23:0] pixel_in,
   output logic        rcv_req,
   input  logic        rcv_ack,
   output logic [23:0] pixel_out,
   input  logic        snd_req,
   output logic        snd_ack
);

   localparam int PIXEL_NUM = WIDTH * HEIGHT;
   localparam int LAT       = WIDTH + LAT_OFS;
   localparam int CW        = $clog2(PIXEL_NUM + 1);
   localparam int XW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int YW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int DW        = $clog2(LAT);

   state_t         state_q;
   logic           in_valid_q;
   logic           gvalid_q;
   logic [CW-1:0]  in_cnt_q;
   logic [DW-1:0]  dly_q;
   logic           oact_q;
   logic           fin_q;
   logic [XW-1:0]  ox_q;
   logic [YW-1:0]  oy_q;
   logic           snd_ack_q;
   logic [23:0]    pixel_out_q;

   logic [7:0]     gray_q;
   logic [7:0]     win_q [3][3];
   logic [7:0]     lb0_out;
   logic [7:0]     lb1_out;

   logic           accept_d;
   logic           border_d;
   logic signed [10:0] gx_d;
   logic signed [10:0] gy_d;
   logic [10:0]    abs_x_d;
   logic [10:0]    abs_y_d;
   logic [11:0]    mag_sum_d;
   logic [7:0]     mag_d;

   assign rcv_req   = (state_q == ST_REQ);
   assign snd_ack   = snd_ack_q;
   assign pixel_out = pixel_out_q;

   // Acks beyond one frame are dropped so a late upstream cannot overrun.
   assign accept_d = rcv_ack && ((state_q == ST_REQ) ||
                     ((state_q == ST_RUN) && (in_cnt_q != CW'(PIXEL_NUM))));

   assign border_d = (ox_q == '0) || (ox_q == XW'(WIDTH - 1)) ||
                     (oy_q == '0) || (oy_q == YW'(HEIGHT - 1));

   line_buf #(.WIDTH(WIDTH)) u_lb0 (
      .clk    (clk),
      .xrst   (xrst),
      .we_i   (gvalid_q),
      .din_i  (gray_q),
      .dout_o (lb0_out)
   );

   line_buf #(.WIDTH(WIDTH)) u_lb1 (
      .clk    (clk),
      .xrst   (xrst),
      .we_i   (gvalid_q),
      .din_i  (lb0_out),
      .dout_o (lb1_out)
   );

   // Data path is unreset; border masking keeps stale samples off the output.
   always_ff @(posedge clk) begin
      if (in_valid_q) begin
         gray_q <= rgb2gray(pixel_in);
      end
      if (gvalid_q) begin
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= win_q[r][2];
         end
         win_q[0][2] <= lb1_out;
         win_q[1][2] <= lb0_out;
         win_q[2][2] <= gray_q;
      end
   end

   always_comb begin
      gx_d = $signed({1'b0, wsum(win_q[0][2], win_q[1][2], win_q[2][2])})
           - $signed({1'b0, wsum(win_q[0][0], win_q[1][0], win_q[2][0])});
      gy_d = $signed({1'b0, wsum(win_q[2][0], win_q[2][1], win_q[2][2])})
           - $signed({1'b0, wsum(win_q[0][0], win_q[0][1], win_q[0][2])});
      abs_x_d   = gx_d[10] ? -gx_d : gx_d;
      abs_y_d   = gy_d[10] ? -gy_d : gy_d;
      mag_sum_d = {1'b0, abs_x_d} + {1'b0, abs_y_d};
      mag_d     = (mag_sum_d > 12'(MAG_MAX)) ? 8'(MAG_MAX) : mag_sum_d[7:0];
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state_q     <= ST_IDLE;
         in_valid_q  <= 1'b0;
         gvalid_q    <= 1'b0;
         in_cnt_q    <= '0;
         dly_q       <= '0;
         oact_q      <= 1'b0;
         fin_q       <= 1'b0;
         ox_q        <= '0;
         oy_q        <= '0;
         snd_ack_q   <= 1'b0;
         pixel_out_q <= '0;
      end else begin
         in_valid_q  <= accept_d;
         gvalid_q    <= in_valid_q;
         snd_ack_q   <= 1'b0;
         pixel_out_q <= '0;
         case (state_q)
            ST_IDLE: begin
               in_cnt_q <= '0;
               dly_q    <= '0;
               oact_q   <= 1'b0;
               fin_q    <= 1'b0;
               ox_q     <= '0;
               oy_q     <= '0;
               if (snd_req) begin
                  state_q <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (accept_d) begin
                  in_cnt_q <= in_cnt_q + 1'b1;
                  state_q  <= ST_RUN;
               end
            end
            default: begin
               if (accept_d) begin
                  in_cnt_q <= in_cnt_q + 1'b1;
               end
               if ((state_q == ST_RUN) && in_valid_q && (in_cnt_q == CW'(PIXEL_NUM))) begin
                  state_q <= ST_FLUSH;
               end
               if ((state_q == ST_FLUSH) && fin_q) begin
                  state_q <= ST_IDLE;
               end
               // Output timing counts from the first RUN cycle (pixel 0 valid).
               if (!oact_q && !fin_q) begin
                  if (dly_q == DW'(LAT - 2)) begin
                     snd_ack_q <= 1'b1;
                     oact_q    <= 1'b1;
                  end else begin
                     dly_q <= dly_q + 1'b1;
                  end
               end
               if (oact_q) begin
                  pixel_out_q <= border_d ? 24'h0 : {mag_d, mag_d, mag_d};
                  if (ox_q == XW'(WIDTH - 1)) begin
                     ox_q <= '0;
                     if (oy_q == YW'(HEIGHT - 1)) begin
                        oact_q <= 1'b0;
                        fin_q  <= 1'b1;
                     end else begin
                        oy_q <= oy_q + 1'b1;
                     end
                  end else begin
                     ox_q <= ox_q + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sobel_rgb_stream.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_sobel_rgb_stream : directed frames with a queue scoreboard for
//                       the Sobel RGB edge stream.          rev 1.0
// ------------------------------------------------------------------
module tb_sobel_rgb_stream;
   import sobel_pkg::*;

   localparam int W   = 128;
   localparam int H   = 128;
   localparam int N   = W * H;
   localparam int LAT = W + 4;

   logic        clk = 1'b0;
   logic        xrst;
   logic [23:0] pixel_in;
   logic        rcv_req;
   logic        rcv_ack;
   logic [23:0] pixel_out;
   logic        snd_req;
   logic        snd_ack;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          c0;
   bit          abort;
   logic [23:0] rgb_img [N];
   int          gimg [N];
   logic [23:0] sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sobel_rgb_stream #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk       (clk),
      .xrst      (xrst),
      .pixel_in  (pixel_in),
      .rcv_req   (rcv_req),
      .rcv_ack   (rcv_ack),
      .pixel_out (pixel_out),
      .snd_req   (snd_req),
      .snd_ack   (snd_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int gray_m(input logic [23:0] v);
      return (77 * int'(v[23:16]) + 150 * int'(v[15:8]) + 29 * int'(v[7:0])) >> 8;
   endfunction

   function automatic int g(input int y, input int x);
      return gimg[y * W + x];
   endfunction

   function automatic logic [23:0] exp_pix(input int k);
      int x, y, gx, gy, m;
      x = k % W;
      y = k / W;
      if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 24'h0;
      gx = (g(y-1, x+1) + 2 * g(y, x+1) + g(y+1, x+1))
         - (g(y-1, x-1) + 2 * g(y, x-1) + g(y+1, x-1));
      gy = (g(y+1, x-1) + 2 * g(y+1, x) + g(y+1, x+1))
         - (g(y-1, x-1) + 2 * g(y-1, x) + g(y-1, x+1));
      m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (m > 255) m = 255;
      return {m[7:0], m[7:0], m[7:0]};
   endfunction

   // mode 0 flat grey, 1 vertical edge, 2 dot at (5,5), 3 dot at (0,0)
   task automatic fill(input int mode);
      for (int k = 0; k < N; k++) begin
         int x, y;
         logic [23:0] v;
         x = k % W;
         y = k / W;
         case (mode)
            0:       v = 24'h808080;
            1:       v = (x >= W / 2) ? 24'hFFFFFF : 24'h000000;
            2:       v = (x == 5 && y == 5) ? 24'h282828 : 24'h000000;
            default: v = (k == 0) ? 24'h282828 : 24'h000000;
         endcase
         rgb_img[k] = v;
         gimg[k]    = gray_m(v);
      end
   endtask

   task automatic run_frame(input int abort_k);
      abort = 1'b0;
      c0    = 0;
      @(posedge clk); #1;
      snd_req = 1'b1;
      @(negedge clk); chk("rcv_req_idle", rcv_req, 0);
      @(negedge clk); chk("rcv_req_up", rcv_req, 1);
      repeat (3) @(posedge clk);
      #1;
      snd_req = 1'b0;
      fork
         begin : drv
            for (int i = 0; i <= N && !abort; i++) begin
               rcv_ack  = (i < N);
               pixel_in = (i > 0) ? rgb_img[i-1] : 24'h0;
               if (i > 0) sb.push_back(exp_pix(i - 1));
               if (i == 1) c0 = cyc;
               @(posedge clk); #1;
            end
            rcv_ack  = 1'b0;
            pixel_in = 24'h0;
         end
         begin : mon
            bit got;
            int n;
            logic [23:0] e;
            @(negedge clk); chk("rcv_req_held", rcv_req, 1);
            @(negedge clk); chk("rcv_req_drop", rcv_req, 0);
            got = 1'b0;
            n   = 0;
            while (!got && n < LAT + 16) begin
               @(negedge clk);
               if (snd_ack === 1'b1) got = 1'b1;
               n++;
            end
            chk("snd_ack_seen", 32'(got), 1);
            chk("snd_ack_lat", cyc - c0, LAT - 1);
            if (got) begin
               for (int k = 0; k < N; k++) begin
                  @(negedge clk);
                  e = (sb.size() > 0) ? sb.pop_front() : 24'hxxxxxx;
                  chk($sformatf("pixel %0d", k), pixel_out, e);
                  if (k == 0) chk("snd_ack_single", snd_ack, 0);
                  if (k == abort_k) begin
                     #1 xrst = 1'b0;
                     #1;
                     chk("rst_pixel_out", pixel_out, 0);
                     chk("rst_snd_ack", snd_ack, 0);
                     chk("rst_rcv_req", rcv_req, 0);
                     chk("rst_state", dut.state_q, ST_IDLE);
                     abort = 1'b1;
                     break;
                  end
               end
               if (!abort) begin
                  @(negedge clk);
                  chk("end_state_idle", dut.state_q, ST_IDLE);
                  chk("end_pixel_zero", pixel_out, 0);
               end
            end
         end
      join
      sb.delete();
      if (abort) begin
         @(negedge clk);
         xrst = 1'b1;
      end
      repeat (4) @(negedge clk);
      chk("idle_no_req", rcv_req, 0);
   endtask

   initial begin
      #(10 * 200000);
      $fatal(1, "FAIL watchdog: simulation did not finish");
   end

   initial begin
      logic [23:0] gp [3];
      int          ge [3];
      gp = '{24'hFF0000, 24'h00FF00, 24'h0000FF};
      ge = '{76, 149, 28};

      xrst     = 1'b0;
      snd_req  = 1'b0;
      rcv_ack  = 1'b0;
      pixel_in = 24'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_rcv_req", rcv_req, 0);
      chk("reset_snd_ack", snd_ack, 0);
      chk("reset_pixel_out", pixel_out, 0);
      chk("reset_state", dut.state_q, ST_IDLE);
      xrst = 1'b1;

      // Grayscale spot checks on the first three pixels of a request
      @(posedge clk); #1 snd_req = 1'b1;
      @(posedge clk); #1 snd_req = 1'b0;
      rcv_ack = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(posedge clk); #1;
         pixel_in = (j < 3) ? gp[j] : 24'h0;
         @(negedge clk);
         if (j > 0) chk($sformatf("gray %0d", j - 1), dut.gray_q, ge[j-1]);
      end
      #1 xrst = 1'b0;
      rcv_ack  = 1'b0;
      pixel_in = 24'h0;
      #1 chk("gray_rst_pixel_out", pixel_out, 0);
      @(negedge clk);
      xrst = 1'b1;

      fill(0); run_frame(-1);
      fill(2); run_frame(-1);
      fill(3); run_frame(-1);
      fill(1); run_frame(5000);
      run_frame(-1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
